// File: rtl/spi_target_pkg.sv
// spi_target_pkg
// Shared types and helpers for the SPI target block.
//   state_e          : controller states (IDLE, ACTIVE)
//   DATA_W_MIN/MAX   : legal word length range for spi_target
//   sample_on_rise() : 1 when the sampling edge of sclk is its rising edge
package spi_target_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam int unsigned DATA_W_MIN = 4;
   localparam int unsigned DATA_W_MAX = 32;

   // Leading edge is the transition away from cpol. Sampling happens on the
   // leading edge for cpha=0 and on the trailing edge for cpha=1, which
   // reduces to "rising edge samples" whenever cpol and cpha agree.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_target_fifo.sv
// spi_target_fifo
// Small synchronous FIFO used as RX word storage when SPI_TARGET_RX_FIFO_EN
// is defined. Depth must be a power of two (>= 2) so pointers wrap freely.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
// Ports:
//   clk_i, rst_ni : system clock, async active-low reset (clears storage too)
//   push, push_data : write request and word
//   pop, pop_data   : read request and head word (valid while !empty)
//   full, empty     : occupancy flags
module spi_target_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign do_push  = push & (~full | pop);
   assign do_pop   = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/spi_target.sv
// spi_target
// SPI target receiver/transmitter. sclk, ss_n and sd are oversampled in the
// clk_i domain (host sclk must be <= clk_i/8); received words leave on a
// valid/ready RX stream, transmit words arrive on a valid/ready TX stream.
// All four CPOL/CPHA modes, MSB- or LSB-first.
//
// Build option: SPI_TARGET_RX_FIFO_EN
//   defined   : RX storage is an RxDepth-entry FIFO (spi_target_fifo)
//   undefined : RX storage is a single holding register, RxDepth unused
//
// Ports:
//   clk_i, rst_ni              : system clock, async active-low reset
//   cfg_cpol_i/cfg_cpha_i      : SPI mode; cfg_lsb_i selects LSB-first
//   ss_ni, sclk_i, sd_i        : raw host pins (asynchronous)
//   sd_o, sd_oe_o              : target data out and its drive enable
//   rx_data_o/valid_o/ready_i  : received word stream
//   tx_data_i/valid_i/ready_o  : transmit word stream (ready is a pulse)
//   rx_overflow_o              : pulse, received word dropped (storage full)
//   tx_underrun_o              : pulse, no TX word at load, all-ones sent
//   busy_o                     : transfer in progress
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ss_n high, sd_o not driven, waiting for ss_n falling edge
// ACTIVE | selected; sampling/shifting on sclk edges until ss_n rises
module spi_target
   import spi_target_pkg::*;
#(
   parameter int unsigned DataW   = 8,
   parameter int unsigned RxDepth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_cpol_i,
   input  logic             cfg_cpha_i,
   input  logic             cfg_lsb_i,
   input  logic             ss_ni,
   input  logic             sclk_i,
   input  logic             sd_i,
   output logic             sd_o,
   output logic             sd_oe_o,
   output logic [DataW-1:0] rx_data_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   input  logic [DataW-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic             rx_overflow_o,
   output logic             tx_underrun_o,
   output logic             busy_o
);

   if (DataW < DATA_W_MIN || DataW > DATA_W_MAX) begin : g_bad_dataw
      $error("spi_target: DataW out of range");
   end
   if (RxDepth < 2 || (RxDepth & (RxDepth - 1)) != 0) begin : g_bad_rxdepth
      $error("spi_target: RxDepth must be a power of two >= 2");
   end

   localparam int unsigned      CNT_W    = $clog2(DataW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DataW - 1);

   // synchronisers and edge detection
   logic ss_meta_q, ss_sync_q, ss_dly_q;
   logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
   logic sd_meta_q, sd_sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ss_meta_q   <= 1'b1;
         ss_sync_q   <= 1'b1;
         ss_dly_q    <= 1'b1;
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_dly_q  <= 1'b0;
         sd_meta_q   <= 1'b0;
         sd_sync_q   <= 1'b0;
      end else begin
         ss_meta_q   <= ss_ni;
         ss_sync_q   <= ss_meta_q;
         ss_dly_q    <= ss_sync_q;
         sclk_meta_q <= sclk_i;
         sclk_sync_q <= sclk_meta_q;
         sclk_dly_q  <= sclk_sync_q;
         sd_meta_q   <= sd_i;
         sd_sync_q   <= sd_meta_q;
      end
   end

   logic ss_fall, ss_rise, sclk_rise, sclk_fall;
   logic samp_rise, sample_edge, shift_edge;

   assign ss_fall     = ~ss_sync_q & ss_dly_q;
   assign ss_rise     = ss_sync_q & ~ss_dly_q;
   assign sclk_rise   = sclk_sync_q & ~sclk_dly_q;
   assign sclk_fall   = ~sclk_sync_q & sclk_dly_q;
   assign samp_rise   = sample_on_rise(cfg_cpol_i, cfg_cpha_i);
   assign sample_edge = samp_rise ? sclk_rise : sclk_fall;
   assign shift_edge  = samp_rise ? sclk_fall : sclk_rise;

   // controller
   state_e state_q, state_d;
   logic   tx_load;
   logic   frame_end;
   logic   word_done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_load   = 1'b0;
      frame_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               tx_load = 1'b1;
            end
         end
         ACTIVE: begin
            // ss_n rising beats a pending reload and any coincident sample
            if (ss_rise) begin
               state_d   = IDLE;
               frame_end = 1'b1;
            end else if (word_done_q) begin
               tx_load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // shift registers and bit counter
   logic [DataW-1:0] tx_shift_q, rx_shift_q;
   logic [DataW-1:0] tx_word, tx_next, rx_next;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             skip_q;
   logic             oe_q;

   assign tx_word = tx_valid_i ? tx_data_i : '1;
   assign tx_next = cfg_lsb_i ? {1'b0, tx_shift_q[DataW-1:1]}
                              : {tx_shift_q[DataW-2:0], 1'b0};
   assign rx_next = cfg_lsb_i ? {sd_sync_q, rx_shift_q[DataW-1:1]}
                              : {rx_shift_q[DataW-2:0], sd_sync_q};

   // skip_q holds the freshly loaded first bit across one shift edge: at
   // frame start only for cpha=1 (leading edge precedes the first sample),
   // and after every mid-frame reload (the shift edge that follows the last
   // sample of the previous word must not consume the new word's first bit).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         skip_q      <= 1'b0;
         oe_q        <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         word_done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (tx_load) begin
               tx_shift_q <= tx_word;
               bit_cnt_q  <= '0;
               skip_q     <= cfg_cpha_i;
               oe_q       <= 1'b1;
            end
         end else if (frame_end) begin
            tx_shift_q <= '0;
            bit_cnt_q  <= '0;
            skip_q     <= 1'b0;
            oe_q       <= 1'b0;
         end else begin
            if (tx_load) begin
               tx_shift_q <= tx_word;
               skip_q     <= 1'b1;
            end else if (shift_edge) begin
               if (skip_q) begin
                  skip_q <= 1'b0;
               end else begin
                  tx_shift_q <= tx_next;
               end
            end
            if (sample_edge) begin
               rx_shift_q <= rx_next;
               if (bit_cnt_q == CNT_LAST) begin
                  bit_cnt_q   <= '0;
                  word_done_q <= 1'b1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign sd_o          = oe_q & (cfg_lsb_i ? tx_shift_q[0] : tx_shift_q[DataW-1]);
   assign sd_oe_o       = oe_q;
   assign busy_o        = (state_q == ACTIVE);
   assign tx_ready_o    = tx_load & tx_valid_i;
   assign tx_underrun_o = tx_load & ~tx_valid_i;

   // RX storage
   logic push, pop, full;

   assign push = word_done_q;
   assign pop  = rx_valid_o & rx_ready_i;

`ifdef SPI_TARGET_RX_FIFO_EN
   logic empty;

   spi_target_fifo #(
      .Width (DataW),
      .Depth (RxDepth)
   ) u_rx_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .push_data (rx_shift_q),
      .pop       (pop),
      .pop_data  (rx_data_o),
      .full      (full),
      .empty     (empty)
   );

   assign rx_valid_o = ~empty;
`else
   logic [DataW-1:0] hold_data_q;
   logic             hold_valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
      end else if (push && (!hold_valid_q || pop)) begin
         hold_data_q  <= rx_shift_q;
         hold_valid_q <= 1'b1;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end

   assign full       = hold_valid_q;
   assign rx_data_o  = hold_data_q;
   assign rx_valid_o = hold_valid_q;
`endif

   // a pop in the same cycle frees the slot, so no drop then
   assign rx_overflow_o = push & full & ~pop;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target
// Directed bench for spi_target (DataW=8, RxDepth=4). A behavioural SPI host
// drives ss_n/sclk/sd; expected RX words are queued when sent and compared
// against words popped from the RX stream.
module tb_spi_target;

   localparam int DW   = 8;
   localparam int HALF = 8;
`ifdef SPI_TARGET_RX_FIFO_EN
   localparam int STORE_N = 4;
`else
   localparam int STORE_N = 1;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cfg_cpol_i, cfg_cpha_i, cfg_lsb_i;
   logic          ss_ni, sclk_i, sd_i;
   logic          sd_o, sd_oe_o;
   logic [DW-1:0] rx_data_o;
   logic          rx_valid_o, rx_ready_i;
   logic [DW-1:0] tx_data_i;
   logic          tx_valid_i, tx_ready_o;
   logic          rx_overflow_o, tx_underrun_o, busy_o;

   spi_target #(.DataW(DW), .RxDepth(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cfg_cpol_i    (cfg_cpol_i),
      .cfg_cpha_i    (cfg_cpha_i),
      .cfg_lsb_i     (cfg_lsb_i),
      .ss_ni         (ss_ni),
      .sclk_i        (sclk_i),
      .sd_i          (sd_i),
      .sd_o          (sd_o),
      .sd_oe_o       (sd_oe_o),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .tx_data_i     (tx_data_i),
      .tx_valid_i    (tx_valid_i),
      .tx_ready_o    (tx_ready_o),
      .rx_overflow_o (rx_overflow_o),
      .tx_underrun_o (tx_underrun_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // monitor: pulse counters and popped RX words
   int            ready_cnt    = 0;
   int            underrun_cnt = 0;
   int            overflow_cnt = 0;
   int            pop_cnt      = 0;
   logic [DW-1:0] obs_mem [256];

   always @(negedge clk_i) begin
      if (tx_ready_o)    ready_cnt++;
      if (tx_underrun_o) underrun_cnt++;
      if (rx_overflow_o) overflow_cnt++;
      if (rx_valid_o && rx_ready_i) begin
         obs_mem[pop_cnt % 256] = rx_data_o;
         pop_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q [$];
   int            rd_idx = 0;
   logic          drop_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock step; drops tx_valid the cycle after the DUT takes the word
   task automatic step();
      logic r;
      @(posedge clk_i);
      #1;
      r = tx_ready_o;
      if (drop_pending) tx_valid_i = 1'b0;
      drop_pending = r;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) step();
   endtask

   task automatic host_frame(input logic cpol, input logic cpha, input logic lsb,
                             input logic [DW-1:0] mosi, input int nbits,
                             input logic raise_ss, input logic refill_en,
                             input logic [DW-1:0] refill, output logic [DW-1:0] miso);
      int idx, nidx;
      miso       = '0;
      cfg_cpol_i = cpol;
      cfg_cpha_i = cpha;
      cfg_lsb_i  = lsb;
      sclk_i     = cpol;
      wait_cyc(HALF);
      ss_ni = 1'b0;
      if (!cpha) begin
         idx  = lsb ? 0 : DW - 1;
         sd_i = mosi[idx];
      end
      wait_cyc(HALF);
      if (refill_en) begin
         tx_data_i  = refill;
         tx_valid_i = 1'b1;
      end
      for (int i = 0; i < nbits; i++) begin
         idx = lsb ? i : DW - 1 - i;
         if (!cpha) begin
            miso[idx] = sd_o;
            sclk_i = ~cpol;
            wait_cyc(HALF);
            sclk_i = cpol;
            if (i + 1 < DW) begin
               nidx = lsb ? i + 1 : DW - 2 - i;
               sd_i = mosi[nidx];
            end
            wait_cyc(HALF);
         end else begin
            sclk_i = ~cpol;
            sd_i   = mosi[idx];
            wait_cyc(HALF);
            miso[idx] = sd_o;
            sclk_i = cpol;
            wait_cyc(HALF);
         end
      end
      if (raise_ss) begin
         ss_ni = 1'b1;
         wait_cyc(HALF);
      end
   endtask

   // compare popped words against the scoreboard queue
   task automatic sb_drain(input string tag);
      int t;
      t = 0;
      while ((pop_cnt - rd_idx) < exp_q.size() && t < 50) begin
         step();
         t++;
      end
      chk({tag, "_count"}, pop_cnt - rd_idx, exp_q.size());
      while (exp_q.size() > 0 && rd_idx < pop_cnt) begin
         chk(tag, 32'(obs_mem[rd_idx % 256]), 32'(exp_q.pop_front()));
         rd_idx++;
      end
      exp_q.delete();
      rd_idx = pop_cnt;
   endtask

   initial begin
      logic [DW-1:0] miso;
      logic [1:0]    md;
      int            base;

      rst_ni     = 1'b0;
      ss_ni      = 1'b1;
      sclk_i     = 1'b0;
      sd_i       = 1'b0;
      cfg_cpol_i = 1'b0;
      cfg_cpha_i = 1'b0;
      cfg_lsb_i  = 1'b0;
      rx_ready_i = 1'b1;
      tx_data_i  = '0;
      tx_valid_i = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_outs", {sd_o, sd_oe_o, busy_o, rx_valid_o, rx_overflow_o, tx_ready_o, tx_underrun_o}, 0);
      chk("reset_rx_data", rx_data_o, 0);
      rst_ni = 1'b1;
      wait_cyc(4);
      chk("idle_busy", busy_o, 0);

      // mode 0, MSB first
      tx_data_i  = 8'h3C;
      tx_valid_i = 1'b1;
      base = ready_cnt;
      exp_q.push_back(8'hA5);
      host_frame(1'b0, 1'b0, 1'b0, 8'hA5, DW, 1'b1, 1'b0, 8'h00, miso);
      chk("m0_miso", miso, 8'h3C);
      chk("m0_tx_ready_pulses", ready_cnt - base, 1);
      chk("m0_oe_after", sd_oe_o, 0);
      sb_drain("m0_rx");

      // all four modes, LSB first
      for (int m = 0; m < 4; m++) begin
         md         = 2'(m);
         tx_data_i  = 8'h7E;
         tx_valid_i = 1'b1;
         exp_q.push_back(8'h81);
         host_frame(md[1], md[0], 1'b1, 8'h81, DW, 1'b1, 1'b0, 8'h00, miso);
         chk($sformatf("mode%0d_miso", m), miso, 8'h7E);
         sb_drain($sformatf("mode%0d_rx", m));
      end

      // underrun at frame start; a word supplied mid-frame covers the reload
      tx_valid_i = 1'b0;
      base = underrun_cnt;
      exp_q.push_back(8'h96);
      host_frame(1'b0, 1'b0, 1'b0, 8'h96, DW, 1'b1, 1'b1, 8'h00, miso);
      chk("underrun_miso", miso, 8'hFF);
      chk("underrun_pulses", underrun_cnt - base, 1);
      sb_drain("underrun_rx");

      // overflow with consumer stalled
      rx_ready_i = 1'b0;
      base = overflow_cnt;
      for (int k = 0; k < 5; k++) begin
         host_frame(1'b0, 1'b0, 1'b0, 8'(8'h11 * (k + 1)), DW, 1'b1, 1'b0, 8'h00, miso);
      end
      chk("ovf_pulses", overflow_cnt - base, 5 - STORE_N);
      chk("ovf_valid", rx_valid_o, 1);
      chk("ovf_head", rx_data_o, 8'h11);
      for (int k = 0; k < STORE_N; k++) exp_q.push_back(8'(8'h11 * (k + 1)));
      rx_ready_i = 1'b1;
      sb_drain("ovf_rx");
      chk("ovf_valid_after", rx_valid_o, 0);

      // aborted partial word, then an intact byte
      base = pop_cnt;
      host_frame(1'b0, 1'b0, 1'b0, 8'hFF, 3, 1'b1, 1'b0, 8'h00, miso);
      chk("partial_no_push", pop_cnt - base, 0);
      chk("partial_idle", {busy_o, sd_oe_o, sd_o}, 0);
      tx_data_i  = 8'hC3;
      tx_valid_i = 1'b1;
      exp_q.push_back(8'h5A);
      host_frame(1'b0, 1'b0, 1'b0, 8'h5A, DW, 1'b1, 1'b0, 8'h00, miso);
      chk("after_partial_miso", miso, 8'hC3);
      sb_drain("after_partial_rx");

      // reset in the middle of a byte with a word held in storage
      rx_ready_i = 1'b0;
      host_frame(1'b0, 1'b0, 1'b0, 8'h77, DW, 1'b1, 1'b0, 8'h00, miso);
      tx_data_i  = 8'hAA;
      tx_valid_i = 1'b1;
      host_frame(1'b0, 1'b0, 1'b0, 8'hE1, 3, 1'b0, 1'b0, 8'h00, miso);
      chk("pre_rst_state", {busy_o, sd_oe_o, rx_valid_o}, 3'b111);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_outs", {sd_o, sd_oe_o, busy_o, rx_valid_o, rx_overflow_o, tx_ready_o, tx_underrun_o}, 0);
      chk("mid_rst_rx_data", rx_data_o, 0);
      ss_ni        = 1'b1;
      sclk_i       = 1'b0;
      sd_i         = 1'b0;
      tx_valid_i   = 1'b0;
      drop_pending = 1'b0;
      rx_ready_i   = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      wait_cyc(4);
      rd_idx = pop_cnt;
      tx_data_i  = 8'h24;
      tx_valid_i = 1'b1;
      exp_q.push_back(8'hDB);
      host_frame(1'b1, 1'b1, 1'b0, 8'hDB, DW, 1'b1, 1'b0, 8'h00, miso);
      chk("post_rst_miso", miso, 8'h24);
      sb_drain("post_rst_rx");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) receiver/transmitter placed directly downstream of the SPI host pins (ss_o, sclk_o, sd_o, sd_i).
- Used as the on-chip loopback peer and as the building block for the SPI device peripheral.
- Oversamples sclk and ss_n in the system clock domain, deserialises words onto a valid/ready RX stream, and serialises words from a valid/ready TX stream.
- Supports all four CPOL/CPHA modes.

Parameters:
- DataW, 8: word length in bits (legal range 4..32).
- RxDepth, 4: RX FIFO entries, power of two; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_cpol_i  in  1  idle level of sclk.
- cfg_cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cfg_lsb_i  in  1  1: LSB first; 0: MSB first.
- ss_ni  in  1  target select from host ss_o bit, active low.
- sclk_i  in  1  serial clock from host.
- sd_i  in  1  host-to-target data.
- sd_o  out  1  target-to-host data.
- sd_oe_o  out  1  sd_o drive enable.
- rx_data_o  out  DataW  received word.
- rx_valid_o  out  1  rx_data_o valid.
- rx_ready_i  in  1  consumer accepts word.
- tx_data_i  in  DataW  word to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX word taken, single-cycle pulse.
- rx_overflow_o  out  1  one-cycle pulse, RX word dropped.
- tx_underrun_o  out  1  one-cycle pulse, no TX word at load.
- busy_o  out  1  transfer in progress (state ACTIVE).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni. All outputs are 0 in reset; the synchronised ss_n resets to 1.
- Synchronisation: ss_ni, sclk_i and sd_i each pass through a 2-flop synchroniser, plus one delay flop for edge detection on sclk and ss_n.
- Clock ratio: host sclk frequency must be ≤ clk_i/8.
- Edges: leading edge = sclk transition away from cfg_cpol_i; trailing edge = transition back. The sample edge is leading when cpha=0 and trailing when cpha=1; the shift edge is the other one.
- States IDLE, ACTIVE, encoded in the package enum.
- IDLE -> ACTIVE on synced ss_n falling edge:
  - bit counter <= 0.
  - TX shift register loads tx_data_i if tx_valid_i, with a tx_ready_o pulse in that cycle.
  - Otherwise it loads all-ones and pulses tx_underrun_o.
  - sd_oe_o = 1 from the following cycle.
- ACTIVE, sample edge: shift the synced sd_i into the RX shift register (direction per cfg_lsb_i) and increment the bit counter.
- ACTIVE, shift edge: advance the TX shift register; sd_o shows the next bit. The first shift edge is skipped when cpha=1.
- Word completion: when the counter reaches DataW-1 on a sample edge, the assembled word is pushed to RX storage in the next cycle and the counter wraps to 0.
  - The next TX word is loaded on the same cycle, with the same tx_ready/underrun rule.
  - If RX storage is full, the word is dropped, rx_overflow_o pulses once, and stored data is unchanged.
- ACTIVE -> IDLE on synced ss_n rising edge, in any state of the counter:
  - A partial word is discarded, with no push and no pulse.
  - Counter cleared, sd_oe_o = 0, sd_o = 0.
- Simultaneous events:
  - ss_n rising in the same cycle as a sample edge: ss_n wins.
  - RX push and rx_ready_i pop in the same cycle on a full store: both occur; no overflow.
- RX stream: rx_valid_o stays high while storage is non-empty. rx_data_o is stable until popped by rx_valid_o && rx_ready_i.
- Mid-operation reset: all state, storage and pulses clear immediately.

Optional Feature:
- SPI_TARGET_RX_FIFO_EN defined: RX storage is an RxDepth-entry FIFO; full when RxDepth words are held.
- Undefined: RX storage is a single holding register; full when rx_valid_o=1; RxDepth is ignored.

Decomposition:
- spi_target_pkg holds: state enum (IDLE, ACTIVE), edge-select function from cpol/cpha, DataW limits constant.
- Sub-module spi_target_fifo: synchronous FIFO, same clock/reset, with push/pop/full/empty; instantiated only under SPI_TARGET_RX_FIFO_EN.

Test Plan:
- Mode 0, MSB first, DataW=8, host sends 0xA5 with tx word 0x3C -> rx_data_o=0xA5 with a one-word rx_valid_o; host samples 0x3C; one tx_ready_o pulse.
- All four modes, LSB first, host 0x81/target 0x7E -> both sides receive correct bytes in every mode.
- No tx_valid_i at ss_n fall -> tx_underrun_o pulses once; host reads 0xFF.
- rx_ready_i=0, 5 bytes sent: with FIFO (RxDepth=4), 4 stored and 1 rx_overflow_o pulse; without FIFO, 1 stored and 4 pulses.
- ss_ni deasserted after 3 bits -> no rx_valid_o; next full byte 0x5A received intact.
- rst_ni asserted mid-byte -> all outputs 0 in the same cycle; after release, the next transfer is correct.
